// File: rtl/sprite_capture_if.sv
// Pixel-stream input, capture control and sprite-RAM write port of sprite_capture.
// Signal names follow the block's established external pinout.
interface sprite_capture_if;
    logic        enable;
    logic        start;
    logic        iVal;
    logic [9:0]  iVGA_X;
    logic [8:0]  iVGA_Y;
    logic [7:0]  iR;
    logic [7:0]  iG;
    logic [7:0]  iB;
    logic [9:0]  topLeft_X;
    logic [8:0]  topLeft_Y;
    logic [13:0] oAddr;
    logic [23:0] oData;
    logic        oWe;
    logic        oBusy;
    logic        oDone;
    logic        oErr;
    logic [13:0] oCount;

    modport master (
        output enable, start, iVal, iVGA_X, iVGA_Y, iR, iG, iB, topLeft_X, topLeft_Y,
        input  oAddr, oData, oWe, oBusy, oDone, oErr, oCount
    );

    modport slave (
        input  enable, start, iVal, iVGA_X, iVGA_Y, iR, iG, iB, topLeft_X, topLeft_Y,
        output oAddr, oData, oWe, oBusy, oDone, oErr, oCount
    );
endinterface

// File: rtl/sprite_capture.sv
// Grabs a BLOCK_WIDTH x BLOCK_HEIGHT window of a VGA pixel stream into sprite RAM,
// starting at the next frame origin (0,0) after a capture request.
module sprite_capture #(
    parameter int unsigned BLOCK_WIDTH  = 90,
    parameter int unsigned BLOCK_HEIGHT = 114,
    parameter bit          KEEP_BLACK   = 1'b1
) (
    input logic             clk,
    input logic             reset,
    sprite_capture_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArm, StCapture} state_e;

    localparam logic [10:0] BwX = 11'(BLOCK_WIDTH);
    localparam logic [9:0]  BhY = 10'(BLOCK_HEIGHT);
    localparam logic [13:0] BwA = 14'(BLOCK_WIDTH);

    state_e      state;
    logic [9:0]  tx;
    logic [8:0]  ty;
    logic [13:0] addr;
    logic [13:0] count;
    logic [23:0] data;
    logic        we;
    logic        done;
    logic        err;

    logic        at_origin;
    logic        capturing;
    logic        in_x;
    logic        in_y;
    logic        in_win;
    logic        last_px;
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic [9:0]  dx;
    logic [8:0]  dy;
    logic [13:0] wr_addr;
    logic [23:0] pix;

    always_comb begin
        at_origin = bus.iVal && (bus.iVGA_X == 10'd0) && (bus.iVGA_Y == 9'd0);
        // The (0,0) pixel that arms the capture is itself the first capture pixel.
        capturing = (state == StCapture) || ((state == StArm) && at_origin);
        x_end     = {1'b0, tx} + BwX;
        y_end     = {1'b0, ty} + BhY;
        in_x      = (bus.iVGA_X >= tx) && ({1'b0, bus.iVGA_X} < x_end);
        in_y      = (bus.iVGA_Y >= ty) && ({1'b0, bus.iVGA_Y} < y_end);
        in_win    = bus.iVal && in_x && in_y;
        last_px   = ({1'b0, bus.iVGA_X} == (x_end - 11'd1)) &&
                    ({1'b0, bus.iVGA_Y} == (y_end - 10'd1));
        dx        = bus.iVGA_X - tx;
        dy        = bus.iVGA_Y - ty;
        wr_addr   = BwA * 14'(dy) + 14'(dx);
        pix       = {bus.iR, bus.iG, bus.iB};
        // Pure black is reserved as the transparent colour for sprite readers.
        if (KEEP_BLACK && (pix == 24'h000000)) pix = 24'h010101;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
            tx    <= '0;
            ty    <= '0;
            addr  <= '0;
            data  <= '0;
            count <= '0;
            we    <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else if (!bus.enable) begin
            we   <= 1'b0;
            done <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        tx    <= bus.topLeft_X;
                        ty    <= bus.topLeft_Y;
                        count <= '0;
                        err   <= 1'b0;
                        state <= StArm;
                    end
                end
                StArm, StCapture: begin
                    if ((state == StCapture) && at_origin) begin
                        // New frame began before the window was complete.
                        state <= StIdle;
                        err   <= 1'b1;
                        done  <= 1'b1;
                    end else if (capturing) begin
                        state <= StCapture;
                        if (in_win) begin
                            we    <= 1'b1;
                            addr  <= wr_addr;
                            data  <= pix;
                            count <= count + 14'd1;
                            if (last_px) begin
                                state <= StIdle;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.oAddr  = addr;
    assign bus.oData  = data;
    assign bus.oWe    = we;
    assign bus.oBusy  = (state != StIdle);
    assign bus.oDone  = done;
    assign bus.oErr   = err;
    assign bus.oCount = count;
endmodule

// File: tb/tb_sprite_capture.sv
// Bench for sprite_capture: directed pixel rasters, expected writes queued by a
// reference model and checked by an independent output monitor.
module tb_sprite_capture;
    localparam int BW = 90;
    localparam int BH = 114;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [23:0] d1;
        logic [23:0] d2;
        logic        done;
        logic        err;
        logic [13:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t q[$];

    int m_st;
    int m_tx;
    int m_ty;
    int m_cnt;
    bit m_err;

    sprite_capture_if bus ();
    sprite_capture_if bus2 ();

    // Second instance sees identical stimulus but keeps black as written.
    assign bus2.enable    = bus.enable;
    assign bus2.start     = bus.start;
    assign bus2.iVal      = bus.iVal;
    assign bus2.iVGA_X    = bus.iVGA_X;
    assign bus2.iVGA_Y    = bus.iVGA_Y;
    assign bus2.iR        = bus.iR;
    assign bus2.iG        = bus.iG;
    assign bus2.iB        = bus.iB;
    assign bus2.topLeft_X = bus.topLeft_X;
    assign bus2.topLeft_Y = bus.topLeft_Y;

    sprite_capture dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sprite_capture #(
        .KEEP_BLACK (1'b0)
    ) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] col(input int x, input int y);
        return {8'(x), 8'(y), 8'h5A};
    endfunction

    // Monitor: every write or done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.oWe || bus.oDone) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out we=%0b done=%0b want none", bus.oWe, bus.oDone);
                end else begin
                    e = q.pop_front();
                    chk("we", 32'(bus.oWe), 32'(e.we));
                    chk("done", 32'(bus.oDone), 32'(e.done));
                    chk("err", 32'(bus.oErr), 32'(e.err));
                    chk("count", 32'(bus.oCount), 32'(e.cnt));
                    if (e.we) begin
                        chk("addr", 32'(bus.oAddr), 32'(e.addr));
                        chk("data", 32'(bus.oData), 32'(e.d1));
                        chk("we_nb", 32'(bus2.oWe), 32'(e.we));
                        chk("data_nb", 32'(bus2.oData), 32'(e.d2));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.iVal   = 1'b0;
        bus.start  = 1'b0;
        bus.enable = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int tx, input int ty);
        bus.start     = 1'b1;
        bus.enable    = 1'b1;
        bus.iVal      = 1'b0;
        bus.topLeft_X = 10'(tx);
        bus.topLeft_Y = 9'(ty);
        if (m_st == 0) begin
            m_st  = 1;
            m_tx  = tx;
            m_ty  = ty;
            m_cnt = 0;
            m_err = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input int x, input int y, input logic [23:0] rgb, input bit en);
        exp_t e;
        bit   zero;
        bit   last;
        zero       = (x == 0) && (y == 0);
        bus.enable = en;
        bus.start  = 1'b0;
        bus.iVal   = 1'b1;
        bus.iVGA_X = 10'(x);
        bus.iVGA_Y = 9'(y);
        {bus.iR, bus.iG, bus.iB} = rgb;
        if (en && m_st == 2 && zero) begin
            m_st  = 0;
            m_err = 1'b1;
            e = '{we: 1'b0, addr: 14'd0, d1: 24'd0, d2: 24'd0, done: 1'b1, err: 1'b1,
                  cnt: 14'(m_cnt)};
            q.push_back(e);
        end else if (en && (m_st == 2 || (m_st == 1 && zero))) begin
            m_st = 2;
            if (x >= m_tx && x < m_tx + BW && y >= m_ty && y < m_ty + BH) begin
                m_cnt++;
                last = (x == m_tx + BW - 1) && (y == m_ty + BH - 1);
                e = '{we: 1'b1, addr: 14'(BW * (y - m_ty) + (x - m_tx)),
                      d1: (rgb == 24'd0) ? 24'h010101 : rgb, d2: rgb, done: last,
                      err: m_err, cnt: 14'(m_cnt)};
                q.push_back(e);
                if (last) m_st = 0;
            end
        end
        @(posedge clk);
        #1;
        bus.iVal   = 1'b0;
        bus.enable = 1'b1;
    endtask

    // Frame origin pixel, then a sub-raster; optional 10-pixel enable gap and early stop.
    task automatic frame(input int x0, input int x1, input int y0, input int y1,
                         input int gap_x, input int gap_y, input int stop_at);
        int gap_left;
        int frozen;
        gap_left = 0;
        frozen   = 0;
        send(0, 0, col(0, 0), 1'b1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (stop_at != 0 && m_cnt >= stop_at) return;
                if (x == 0 && y == 0) continue;
                if (x == gap_x && y == gap_y) begin
                    gap_left = 10;
                    frozen   = m_cnt;
                end
                if (gap_left > 0) begin
                    send(x, y, col(x, y), 1'b0);
                    gap_left--;
                    if (gap_left == 0) begin
                        chk("we_gap", 32'(bus.oWe), 32'd0);
                        chk("cnt_frozen", 32'(bus.oCount), 32'(frozen));
                    end
                end else begin
                    send(x, y, col(x, y), 1'b1);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_st  = 0;
        m_tx  = 0;
        m_ty  = 0;
        m_cnt = 0;
        m_err = 1'b0;
        bus.enable    = 1'b1;
        bus.start     = 1'b0;
        bus.iVal      = 1'b0;
        bus.iVGA_X    = '0;
        bus.iVGA_Y    = '0;
        bus.iR        = '0;
        bus.iG        = '0;
        bus.iB        = '0;
        bus.topLeft_X = '0;
        bus.topLeft_Y = '0;
        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.oWe), 32'd0);
        chk("rst_done", 32'(bus.oDone), 32'd0);
        chk("rst_err", 32'(bus.oErr), 32'd0);
        chk("rst_busy", 32'(bus.oBusy), 32'd0);
        chk("rst_count", 32'(bus.oCount), 32'd0);
        chk("rst_addr", 32'(bus.oAddr), 32'd0);
        chk("rst_data", 32'(bus.oData), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Black pixel remap at origin (0,0), then abort on the next frame start.
        do_start(0, 0);
        chk("busy_arm", 32'(bus.oBusy), 32'd1);
        send(0, 0, 24'h000000, 1'b1);
        send(1, 0, col(1, 0), 1'b1);
        send(0, 0, col(0, 0), 1'b1);
        idle(3);
        chk("err_held", 32'(bus.oErr), 32'd1);
        chk("busy_after_abort", 32'(bus.oBusy), 32'd0);

        // Full window at (100,50); restart with a different origin is ignored.
        do_start(100, 50);
        chk("err_cleared", 32'(bus.oErr), 32'd0);
        chk("count_cleared", 32'(bus.oCount), 32'd0);
        do_start(5, 5);
        bus.topLeft_X = 10'd7;
        bus.topLeft_Y = 9'd9;
        frame(98, 191, 48, 165, -1, -1, 0);
        idle(3);
        chk("full_count", 32'(bus.oCount), 32'd10260);
        chk("full_err", 32'(bus.oErr), 32'd0);
        chk("full_busy", 32'(bus.oBusy), 32'd0);
        chk("full_drained", 32'(q.size()), 32'd0);

        // Window clipped by the screen edge; the next frame start aborts it.
        do_start(600, 400);
        frame(596, 639, 398, 479, -1, -1, 0);
        send(0, 0, col(0, 0), 1'b1);
        idle(3);
        chk("clip_count", 32'(bus.oCount), 32'd3200);
        chk("clip_err", 32'(bus.oErr), 32'd1);
        chk("clip_busy", 32'(bus.oBusy), 32'd0);

        // Reset after 500 writes abandons the capture immediately.
        do_start(20, 20);
        frame(20, 109, 20, 30, -1, -1, 500);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        m_st  = 0;
        m_cnt = 0;
        m_err = 1'b0;
        chk("mid_rst_we", 32'(bus.oWe), 32'd0);
        chk("mid_rst_busy", 32'(bus.oBusy), 32'd0);
        chk("mid_rst_count", 32'(bus.oCount), 32'd0);
        chk("mid_rst_addr", 32'(bus.oAddr), 32'd0);
        chk("mid_rst_data", 32'(bus.oData), 32'd0);
        chk("mid_rst_drained", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Clean capture after reset with a 10-pixel enable gap mid-row.
        do_start(10, 10);
        chk("restart_count", 32'(bus.oCount), 32'd0);
        frame(10, 99, 10, 123, 40, 20, 0);
        idle(3);
        chk("gap_count", 32'(bus.oCount), 32'd10250);
        chk("gap_err", 32'(bus.oErr), 32'd0);
        chk("gap_busy", 32'(bus.oBusy), 32'd0);
        chk("gap_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
